add_fp_pipe: RTL and testbench
==============================

# add_fp_pipe

Pipelined, parametrised floating-point add/subtract unit; successor to the single-cycle combinational adder in `single/`. It accepts one operand pair per cycle over a valid/ready handshake and returns an IEEE-754-style result with NZCV flags three cycles later. Unlike the earlier adder, it adds a subtract mode, leading-zero normalisation after cancellation, round-to-nearest-even, and zero/inf/NaN handling. It sits between the operand register file and the FPU result/flags writeback, and back-pressure stalls it.

## Interface
- `MANTISA_WIDTH`, default 23: stored fraction bits; the hidden bit is implicit.
- `EXPONENT_WIDTH`, default 8: biased exponent bits. Word width W = MANTISA_WIDTH+EXPONENT_WIDTH+1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  unit accepts this cycle.
- `op`  in  1  0 = a+b, 1 = a−b (sign of b inverted at entry).
- `a`, `b`  in  W  operands {sign, exponent, fraction}.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts this cycle.
- `res_add`  out  W  result.
- `flags_add`  out  4  {N,Z,C,V}.

## Operation
- Stage S1 (unpack/align):
  - Classify each operand as zero (exp=0, denormals flushed to zero), inf (exp all-ones, frac=0), NaN (exp all-ones, frac≠0), or normal.
  - Swap so the larger magnitude is X.
  - Shift Y right by the exponent difference into MANTISA_WIDTH+4 bits, giving hidden, fraction, guard, round and sticky.
  - A shift ≥ MANTISA_WIDTH+3 leaves only sticky.
- Stage S2 (add):
  - Effective add when the signs are equal, otherwise X−Y.
  - Width is MANTISA_WIDTH+5, so carry is kept.
  - Result sign is sign(X).
- Stage S3 (normalise/round/pack):
  - On carry-out: shift right 1 and exponent+1; this sets C.
  - Otherwise: leading-zero count, shift left, and subtract the count from the exponent.
  - RNE on guard/round/sticky. A rounding overflow renormalises and increments the exponent.
  - Exponent ≥ all-ones → ±inf (frac 0) and V=1.
  - Exponent ≤ 0 → signed zero (flush).
- Specials (resolved in S1, carried as a bypass result):
  - Any NaN, or inf−inf → canonical quiet NaN {0, all-ones, 1000…0}, V=1.
  - inf±finite → that inf.
  - x + 0 → x.
  - Exact cancellation and 0+0 of opposite signs → +0; (−0)+(−0) → −0.
- Flags:
  - N = result sign bit.
  - Z = exponent and fraction both zero.
  - C = mantissa carry-out in S2 on an effective add.
  - V = overflow-to-inf or invalid. All flags are 0 for bypassed non-invalid specials, except N and Z.

## Timing
- Latency is exactly 3 cycles from the accepting edge (in_valid & in_ready) to out_valid with no stall. Throughput is 1 per cycle.
- Global advance `en = !out_valid | out_ready`; `in_ready = en` (combinational).
- When `en`=0 all stage registers hold. `res_add`/`flags_add` are stable while `out_valid & !out_ready`.
- A bubble (in_valid=0 while en=1) propagates as an invalid stage. Results are always in order; none are dropped or duplicated.
- Reset: on the reset edge all stage valids, out_valid, res_add and flags_add go to 0. `in_ready` reads 1 in the first cycle after reset.
- Reset mid-operation discards every in-flight result. No output appears for them.
- If reset and in_valid are both asserted on the same edge, reset wins and the operand is not accepted.

## Structure
- Package `fp_pkg`:
  - Class enum {ZERO, NORM, INF, NAN}.
  - Canonical NaN/inf constants as functions of the widths.
  - Flag bit index constants N=3, Z=2, C=1, V=0.
- Sub-module `lzc` (parametrised leading-zero counter, width MANTISA_WIDTH+5), used in S3. Stage logic stays in `add_fp_pipe`.

## Test plan
(Default widths.)
- 1.0+1.0: a=0x3F800000, b=0x3F800000, op=0 → res 0x40000000, flags 0b0010, out_valid exactly 3 cycles after accept.
- Cancellation: a=0x3F800000, b=0x3F800000, op=1 → 0x00000000, flags 0b0100. Also 1.5−1.25 (0x3FC00000, 0x3FA00000, op=1) → 0x3E800000, flags 0b0000 (LZC shift 2).
- Overflow and invalid:
  - 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, flags 0b0011.
  - 0x7F800000−0x7F800000 (op=1) → 0x7FC00000, flags 0b0001.
- Rounding:
  - 0x3F800000+0x33800000 (tie) → 0x3F800000 (even).
  - 0x3F800001+0x33800000 → 0x3F800002.
- Back-pressure:
  - Stream 8 random pairs with out_ready low for 5 cycles mid-stream.
  - All 8 results appear in order, match the model, and outputs hold while stalled.
  - in_ready is low exactly while out_valid & !out_ready.
- Reset with 3 ops in flight → out_valid stays 0 and no stale result appears. A subsequent 2.0+(−3.0) (0x40000000, 0xC0400000) → 0xBF800000, flags 0b1000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the pipelined floating-point adder.
// Classification enum, flag bit positions and width-parametric special encodings.
package fp_pkg;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  localparam int FP_MAXW = 128;

  // Positive infinity: exponent all ones, fraction zero (truncate to the word width).
  function automatic logic [FP_MAXW-1:0] fp_inf(input int mw, input int ew);
    logic [FP_MAXW-1:0] v;
    v = '0;
    for (int i = 0; i < ew; i++) v[mw+i] = 1'b1;
    return v;
  endfunction

  // Canonical quiet NaN: positive, exponent all ones, fraction MSB set.
  function automatic logic [FP_MAXW-1:0] fp_qnan(input int mw, input int ew);
    logic [FP_MAXW-1:0] v;
    v = fp_inf(mw, ew);
    v[mw-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/lzc.sv
// Leading-zero counter; combinational, no backpressure.
// An all-zero input returns WIDTH.
module lzc #(
  parameter int WIDTH = 28,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CW-1:0]    cnt_o
);

  // Later iterations override, so the highest set bit decides the count.
  always_comb begin
    cnt_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) cnt_o = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/add_fp_pipe.sv
// Pipelined FP add/sub with NZCV flags; 3-cycle latency, one op per cycle.
// Single global advance: every stage holds while out_valid & !out_ready, in_ready follows it.
module add_fp_pipe
  import fp_pkg::*;
#(
  parameter int MANTISA_WIDTH  = 23,
  parameter int EXPONENT_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  op,
  input  logic [MANTISA_WIDTH+EXPONENT_WIDTH:0] a,
  input  logic [MANTISA_WIDTH+EXPONENT_WIDTH:0] b,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [MANTISA_WIDTH+EXPONENT_WIDTH:0] res_add,
  output logic [3:0]                            flags_add
);

  localparam int M   = MANTISA_WIDTH;
  localparam int E   = EXPONENT_WIDTH;
  localparam int W   = M + E + 1;
  localparam int AW  = M + 4;
  localparam int SW  = M + 5;
  localparam int LZW = $clog2(SW + 1);
  localparam logic [FP_MAXW-1:0] QNAN_F = fp_qnan(M, E);
  localparam logic [FP_MAXW-1:0] INF_F  = fp_inf(M, E);
  localparam logic [W-1:0]       QNAN   = QNAN_F[W-1:0];
  localparam logic [W-1:0]       INF_P  = INF_F[W-1:0];
  localparam logic [E-1:0]       SH_MAX = E'(M + 3);

  function automatic fp_class_e classify(input logic [W-1:0] v);
    if (v[W-2:M] == '0)  return ZERO;
    else if (&v[W-2:M])  return (v[M-1:0] == '0) ? INF : NAN;
    else                 return NORM;
  endfunction

  logic en;
  logic s1_vld_q, s2_vld_q, out_vld_q;
  logic [W-1:0] res_q, res_d;
  logic [3:0]   flg_q, flg_d;

  assign en        = !out_vld_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_vld_q;
  assign res_add   = res_q;
  assign flags_add = flg_q;

  // Stage 1: classify, resolve specials, order by magnitude, align the smaller operand.
  logic [W-1:0]  b_eff;
  fp_class_e     cls_a, cls_b;
  logic          swap, y_lost;
  logic [E-1:0]  x_exp, y_exp, diff;
  logic [M-1:0]  x_frac, y_frac;
  logic [AW-1:0] y_ext, y_sh;
  logic          s1_byp_d, s1_sign_d, s1_sub_d;
  logic [W-1:0]  s1_bres_d;
  logic [3:0]    s1_bflg_d;
  logic [E-1:0]  s1_exp_d;
  logic [AW-1:0] s1_mx_d, s1_my_d;

  always_comb begin
    b_eff  = {b[W-1] ^ op, b[W-2:0]};
    cls_a  = classify(a);
    cls_b  = classify(b_eff);
    swap   = b_eff[W-2:0] > a[W-2:0];
    x_exp  = swap ? b_eff[W-2:M] : a[W-2:M];
    y_exp  = swap ? a[W-2:M] : b_eff[W-2:M];
    x_frac = swap ? b_eff[M-1:0] : a[M-1:0];
    y_frac = swap ? a[M-1:0] : b_eff[M-1:0];
    diff   = x_exp - y_exp;
    y_ext  = {1'b1, y_frac, 3'b000};
    y_sh   = y_ext >> diff;
    y_lost = |(y_ext & ~({AW{1'b1}} << diff));
    if (diff >= SH_MAX) s1_my_d = {{(AW-1){1'b0}}, 1'b1};
    else                s1_my_d = {y_sh[AW-1:1], y_sh[0] | y_lost};
    s1_mx_d   = {1'b1, x_frac, 3'b000};
    s1_exp_d  = x_exp;
    s1_sign_d = swap ? b_eff[W-1] : a[W-1];
    s1_sub_d  = a[W-1] ^ b_eff[W-1];

    s1_byp_d  = 1'b1;
    s1_bflg_d = '0;
    s1_bres_d = '0;
    if (cls_a == NAN || cls_b == NAN ||
        (cls_a == INF && cls_b == INF && s1_sub_d)) begin
      s1_bres_d        = QNAN;
      s1_bflg_d[FLG_V] = 1'b1;
    end else if (cls_a == INF)                    s1_bres_d = a;
    else if (cls_b == INF)                        s1_bres_d = b_eff;
    else if (cls_a == ZERO && cls_b == ZERO)      s1_bres_d = {a[W-1] & b_eff[W-1], {(W-1){1'b0}}};
    else if (cls_b == ZERO)                       s1_bres_d = a;
    else if (cls_a == ZERO)                       s1_bres_d = b_eff;
    else                                          s1_byp_d  = 1'b0;
    s1_bflg_d[FLG_N] = s1_bres_d[W-1];
    s1_bflg_d[FLG_Z] = (s1_bres_d[W-2:0] == '0);
  end

  logic          s1_byp_q, s1_sign_q, s1_sub_q;
  logic [W-1:0]  s1_bres_q;
  logic [3:0]    s1_bflg_q;
  logic [E-1:0]  s1_exp_q;
  logic [AW-1:0] s1_mx_q, s1_my_q;

  // Stage 2: magnitude add or subtract with the carry bit kept.
  logic [SW-1:0] s2_sum_d;
  assign s2_sum_d = s1_sub_q ? ({1'b0, s1_mx_q} - {1'b0, s1_my_q})
                             : ({1'b0, s1_mx_q} + {1'b0, s1_my_q});

  logic          s2_byp_q, s2_sign_q;
  logic [W-1:0]  s2_bres_q;
  logic [3:0]    s2_bflg_q;
  logic [E-1:0]  s2_exp_q;
  logic [SW-1:0] s2_sum_q;

  always_ff @(posedge clk) begin
    if (en) begin
      s1_byp_q  <= s1_byp_d;  s1_sign_q <= s1_sign_d; s1_sub_q <= s1_sub_d;
      s1_bres_q <= s1_bres_d; s1_bflg_q <= s1_bflg_d; s1_exp_q <= s1_exp_d;
      s1_mx_q   <= s1_mx_d;   s1_my_q   <= s1_my_d;
      s2_byp_q  <= s1_byp_q;  s2_sign_q <= s1_sign_q; s2_bres_q <= s1_bres_q;
      s2_bflg_q <= s1_bflg_q; s2_exp_q  <= s1_exp_q;  s2_sum_q  <= s2_sum_d;
    end
  end

  // Stage 3: normalise, round to nearest even, detect overflow/underflow, pack.
  logic [LZW-1:0] lz, sh;
  logic           carry, round_up;
  logic [AW-1:0]  norm;
  logic [M+1:0]   mant_r;
  logic [E+1:0]   exp_n, e_f;
  logic [M-1:0]   frac;

  lzc #(.WIDTH(SW)) u_lzc (.in_i(s2_sum_q), .cnt_o(lz));

  always_comb begin
    carry = s2_sum_q[SW-1];
    sh    = lz - LZW'(1);
    if (carry) begin
      norm  = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n = {2'b00, s2_exp_q} + (E+2)'(1);
    end else begin
      norm  = s2_sum_q[AW-1:0] << sh;
      exp_n = {2'b00, s2_exp_q} - (E+2)'(sh);
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[AW-1:3]} + (M+2)'(round_up);
    e_f      = exp_n + (E+2)'(mant_r[M+1]);
    frac     = mant_r[M+1] ? mant_r[M:1] : mant_r[M-1:0];

    flg_d        = '0;
    flg_d[FLG_C] = carry;
    if (s2_byp_q) begin
      res_d = s2_bres_q;
      flg_d = s2_bflg_q;
    end else if (s2_sum_q == '0) begin
      res_d        = '0;
      flg_d        = '0;
      flg_d[FLG_Z] = 1'b1;
    end else if (e_f[E+1] || e_f == '0) begin
      res_d        = {s2_sign_q, {(W-1){1'b0}}};
      flg_d[FLG_N] = s2_sign_q;
      flg_d[FLG_Z] = 1'b1;
    end else if (e_f >= {2'b00, {E{1'b1}}}) begin
      res_d        = {s2_sign_q, INF_P[W-2:0]};
      flg_d[FLG_N] = s2_sign_q;
      flg_d[FLG_V] = 1'b1;
    end else begin
      res_d        = {s2_sign_q, e_f[E-1:0], frac};
      flg_d[FLG_N] = s2_sign_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      res_q     <= '0;
      flg_q     <= '0;
    end else if (en) begin
      s1_vld_q  <= in_valid;
      s2_vld_q  <= s1_vld_q;
      out_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        res_q <= res_d;
        flg_q <= flg_d;
      end
    end
  end

endmodule

// File: tb/tb_add_fp_pipe.sv
// Directed-vector bench for add_fp_pipe: scoreboarded results, latency, stall hold and reset flush.
module tb_add_fp_pipe;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
    logic [31:0] cyc;
    logic [7:0]  idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] a, b, res_add;
  logic [3:0]  flags_add;

  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] cyc = '0;
  logic        lat_chk = 1'b1;
  logic [31:0] cur_res;
  logic [3:0]  cur_flg;
  logic [7:0]  cur_idx;
  exp_t        exp_q[$];
  exp_t        e_pop, e_push;
  logic        stalled_prev = 1'b0;
  logic [31:0] prev_res;
  logic [3:0]  prev_flg;

  vec_t dir_v [0:10] = '{
    '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0010},
    '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0100},
    '{32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 4'b0000},
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0011},
    '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0001},
    '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000},
    '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0000},
    '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b1100},
    '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0100},
    '{32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 4'b0000},
    '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000}
  };

  vec_t bp_v [0:7] = '{
    '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000},
    '{32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0010},
    '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000},
    '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b1000},
    '{32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000, 4'b1010},
    '{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 4'b0000},
    '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000},
    '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0001}
  };

  vec_t fin_v = '{32'h40000000, 32'hC0400000, 1'b0, 32'hBF800000, 4'b1000};

  add_fp_pipe #(.MANTISA_WIDTH(23), .EXPONENT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res_add(res_add), .flags_add(flags_add)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Scoreboard and protocol observer, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        check("hold_vld", out_valid, 1);
        check("hold_res", res_add, prev_res);
        check("hold_flg", flags_add, prev_flg);
      end
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", res_add, 64'hDEAD_0000_0000);
        end else begin
          e_pop = exp_q.pop_front();
          check($sformatf("res[%0d]", e_pop.idx), res_add, e_pop.res);
          check($sformatf("flg[%0d]", e_pop.idx), flags_add, e_pop.flg);
          if (lat_chk) check($sformatf("lat[%0d]", e_pop.idx), cyc - e_pop.cyc, 3);
        end
      end
      if (in_valid && in_ready) begin
        e_push.res = cur_res;
        e_push.flg = cur_flg;
        e_push.cyc = cyc;
        e_push.idx = cur_idx;
        exp_q.push_back(e_push);
      end
      stalled_prev = out_valid && !out_ready;
      prev_res     = res_add;
      prev_flg     = flags_add;
    end
  end

  task automatic send(input vec_t v, input int idx);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    a        = v.a;
    b        = v.b;
    op       = v.op;
    cur_res  = v.res;
    cur_flg  = v.flg;
    cur_idx  = 8'(idx);
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    cur_res = '0; cur_flg = '0; cur_idx = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_res", res_add, 0);
    check("rst_flags", flags_add, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) send(dir_v[i], i);
    in_valid = 1'b0;
    drain("drain_directed");

    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(bp_v[i], 100 + i);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    out_ready = 1'b0;
    send(dir_v[0], 200);
    send(dir_v[5], 201);
    send(dir_v[9], 202);
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("inflight_vld", out_valid, 1);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1);
    check("flush_res", res_add, 0);
    for (int i = 0; i < 5; i++) begin
      check("flush_vld", out_valid, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    lat_chk = 1'b1;
    send(fin_v, 250);
    in_valid = 1'b0;
    drain("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
